// File: rtl/tmr_vote_reg.sv
// ============================================================================
// tmr_vote_reg -- registered triple-modular-redundancy word voter
//
// Purpose:
//   Votes three WIDTH-bit channel words bit-wise (2-of-3) and registers the
//   result. Each channel has an enable. On top of the plain vote the block
//   provides:
//     - a per-channel miscompare flag for the last voted sample,
//     - a per-channel count of consecutive miscompares,
//     - a per-channel fault latch that also excludes the channel from voting,
//     - a quorum-loss flag when fewer than two channels take part.
//   The block sits at the output of triplicated register or ALU lanes.
//
// Parameters:
//   WIDTH       channel word width in bits
//   FAULT_LIMIT consecutive miscompared samples that latch a fault
//               (legal range 1 .. 2**CNT_W-1)
//   CNT_W       width of each consecutive-miscompare counter
//   INVERT      1: y is the complemented majority (NAND-style voter)
//               0: y is the true majority
//
// Optional feature:
//   TMR_ERR_INJECT_EN  when defined, adds the inj_sel / inj_mask ports. On a
//                      valid sample, each selected channel has its word XORed
//                      with inj_mask before gating, voting and miscompare.
//                      The effect lasts for that single sample only.
//
// Ports:
//   clk        in   1      system clock
//   rst        in   1      synchronous active-high reset
//   valid      in   1      sample strobe
//   en         in   3      per-channel enable (bit k gates channel k+1)
//   a1,a2,a3   in   WIDTH  channel words
//   fault_clr  in   3      per-channel fault clear
//   inj_sel    in   3      (TMR_ERR_INJECT_EN only) channels to corrupt
//   inj_mask   in   WIDTH  (TMR_ERR_INJECT_EN only) XOR corruption mask
//   y          out  WIDTH  registered vote
//   y_valid    out  1      high one cycle after a voted sample
//   miscmp     out  3      per-channel miscompare flags of the last sample
//   fault      out  3      latched per-channel fault
//   no_quorum  out  1      fewer than two channels effective
//
// Sample semantics:
//   There is no back-pressure. Every cycle with valid=1 is a sample that is
//   voted; the result (y, miscmp) appears exactly one clock later together
//   with y_valid=1. On valid=0 cycles y and miscmp hold and y_valid is 0.
// ============================================================================
module tmr_vote_reg #(
    parameter int WIDTH       = 26,
    parameter int FAULT_LIMIT = 3,
    parameter int CNT_W       = 4,
    parameter bit INVERT      = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [2:0]       en,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    input  logic [WIDTH-1:0] a3,
    input  logic [2:0]       fault_clr,
`ifdef TMR_ERR_INJECT_EN
    input  logic [2:0]       inj_sel,
    input  logic [WIDTH-1:0] inj_mask,
`endif
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic [2:0]       miscmp,
    output logic [2:0]       fault,
    output logic             no_quorum
);

    // Counter thresholds, sized to the counter so comparisons stay width-clean.
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(FAULT_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(FAULT_LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Reset value of y: the vote of three all-zero words in the chosen polarity.
    localparam logic [WIDTH-1:0] Y_RST = {WIDTH{INVERT}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt [3];          // consecutive-miscompare counters

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] ch    [3];        // channel words after optional injection
    logic [WIDTH-1:0] gated [3];        // words after effective-enable gating
    logic [2:0]       eff;              // effective enables
    logic [WIDTH-1:0] maj;              // bit-wise 2-of-3 majority
    logic [WIDTH-1:0] vote_word;        // majority in output polarity
    logic [2:0]       mis;              // per-channel miscompare of this sample
    logic [1:0]       eff_cnt;          // number of effective channels
    logic             quorum_lost;      // fewer than two effective channels

    logic [CNT_W-1:0] cnt_nxt [3];
    logic [2:0]       fault_nxt;

    // A faulted channel drops out of the vote until it is explicitly cleared.
    assign eff = en & ~fault;

    always_comb begin
        ch[0] = a1;
        ch[1] = a2;
        ch[2] = a3;
`ifdef TMR_ERR_INJECT_EN
        // Corruption is applied only to the sample being voted.
        for (int k = 0; k < 3; k++) begin
            if (valid && inj_sel[k]) begin
                ch[k] = ch[k] ^ inj_mask;
            end
        end
`endif
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            gated[k] = eff[k] ? ch[k] : '0;
        end
    end

    // With one or zero effective channels at most one gated word is non-zero,
    // so the majority naturally collapses to all zeros.
    assign maj = (gated[0] & gated[1]) |
                 (gated[0] & gated[2]) |
                 (gated[1] & gated[2]);

    assign vote_word = INVERT ? ~maj : maj;

    // A disabled or faulted channel never reports a miscompare. The ungated
    // word is compared so a channel is judged on what it actually produced.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            mis[k] = eff[k] & (ch[k] != maj);
        end
    end

    assign eff_cnt     = {1'b0, eff[0]} + {1'b0, eff[1]} + {1'b0, eff[2]};
    assign quorum_lost = (eff_cnt < 2'd2);

    // ------------------------------------------------------------------
    // Counter and fault next-state
    // ------------------------------------------------------------------
    // Counters only move on valid samples of effective channels while a
    // quorum exists. Without a quorum the majority is meaningless, so no
    // channel can be blamed: counters hold and no faults are set.
    // The fault latches on the sample whose miscompare brings the counter to
    // FAULT_LIMIT, so the channel is excluded from the very next sample.
    // A clear always wins over a same-cycle set.
    always_comb begin
        fault_nxt = fault;
        for (int k = 0; k < 3; k++) begin
            cnt_nxt[k] = cnt[k];
            if (valid && !quorum_lost && eff[k]) begin
                if (mis[k]) begin
                    if (cnt[k] < LIMIT) begin
                        cnt_nxt[k] = cnt[k] + CNT_ONE;
                    end
                    if (cnt[k] >= LIMIT_M1) begin
                        fault_nxt[k] = 1'b1;
                    end
                end else begin
                    cnt_nxt[k] = '0;
                end
            end
            if (fault_clr[k]) begin
                cnt_nxt[k]   = '0;
                fault_nxt[k] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            y         <= Y_RST;
            y_valid   <= 1'b0;
            miscmp    <= 3'b000;
            fault     <= 3'b000;
            no_quorum <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            if (valid) begin
                y      <= vote_word;
                miscmp <= mis;
            end
            y_valid   <= valid;
            fault     <= fault_nxt;
            no_quorum <= quorum_lost;
            for (int k = 0; k < 3; k++) begin
                cnt[k] <= cnt_nxt[k];
            end
        end
    end

endmodule

// File: tb/tb_tmr_vote_reg.sv
// ============================================================================
// tb_tmr_vote_reg -- directed testbench for tmr_vote_reg (default parameters:
// WIDTH=26, FAULT_LIMIT=3, CNT_W=4, INVERT=1).
//
// Inputs are driven 1 ns after the rising edge; outputs are checked at the
// same point, i.e. after the registers have settled for the edge just taken.
// Expected values are hand-computed constants.
// ============================================================================
module tb_tmr_vote_reg;

    localparam int WIDTH = 26;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             valid;
    logic [2:0]       en;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] a2;
    logic [WIDTH-1:0] a3;
    logic [2:0]       fault_clr;
`ifdef TMR_ERR_INJECT_EN
    logic [2:0]       inj_sel;
    logic [WIDTH-1:0] inj_mask;
`endif
    logic [WIDTH-1:0] y;
    logic             y_valid;
    logic [2:0]       miscmp;
    logic [2:0]       fault;
    logic             no_quorum;

    tmr_vote_reg dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .en        (en),
        .a1        (a1),
        .a2        (a2),
        .a3        (a3),
        .fault_clr (fault_clr),
`ifdef TMR_ERR_INJECT_EN
        .inj_sel   (inj_sel),
        .inj_mask  (inj_mask),
`endif
        .y         (y),
        .y_valid   (y_valid),
        .miscmp    (miscmp),
        .fault     (fault),
        .no_quorum (no_quorum)
    );

    // ------------------------------------------------------------------
    // Scoreboard counters and helpers
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [WIDTH-1:0] e_y, input logic e_yv,
                             input logic [2:0] e_mis, input logic [2:0] e_fault, input logic e_nq);
        check({tag, ".y"},         32'(y),         32'(e_y));
        check({tag, ".y_valid"},   32'(y_valid),   32'(e_yv));
        check({tag, ".miscmp"},    32'(miscmp),    32'(e_mis));
        check({tag, ".fault"},     32'(fault),     32'(e_fault));
        check({tag, ".no_quorum"}, 32'(no_quorum), 32'(e_nq));
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        rst       = 1'b1;
        valid     = 1'b0;
        en        = 3'b111;
        a1        = '0;
        a2        = '0;
        a3        = '0;
        fault_clr = 3'b000;
`ifdef TMR_ERR_INJECT_EN
        inj_sel   = 3'b000;
        inj_mask  = '0;
`endif
        tick();
        tick();
        check_all("reset", 26'h3FF_FFFF, 1'b0, 3'b000, 3'b000, 1'b0);
        check("reset.cnt1", 32'(dut.cnt[1]), 32'd0);

        // All channels agree: inverted word out one clock later.
        rst   = 1'b0;
        valid = 1'b1;
        a1 = 26'h155_5555; a2 = 26'h155_5555; a3 = 26'h155_5555;
        tick();
        check_all("agree", 26'h2AA_AAAA, 1'b1, 3'b000, 3'b000, 1'b0);

        // Idle cycle: y and miscmp hold, y_valid drops.
        valid = 1'b0;
        a1 = 26'h000_0000;
        tick();
        check_all("idle", 26'h2AA_AAAA, 1'b0, 3'b000, 3'b000, 1'b0);

        // Channel 2 miscompares three samples in a row -> fault[1].
        valid = 1'b1;
        a1 = 26'h3FF_FF00; a2 = 26'h000_00FF; a3 = 26'h3FF_FF00;
        tick();
        check_all("ch2_mis1", 26'h000_00FF, 1'b1, 3'b010, 3'b000, 1'b0);
        check("ch2_mis1.cnt1", 32'(dut.cnt[1]), 32'd1);
        tick();
        check_all("ch2_mis2", 26'h000_00FF, 1'b1, 3'b010, 3'b000, 1'b0);
        check("ch2_mis2.cnt1", 32'(dut.cnt[1]), 32'd2);
        tick();
        check_all("ch2_mis3", 26'h000_00FF, 1'b1, 3'b010, 3'b010, 1'b0);
        check("ch2_mis3.cnt1", 32'(dut.cnt[1]), 32'd3);

        // Faulted channel 2 is excluded: no miscompare from it.
        a2 = 26'h3FF_FFFF;
        tick();
        check_all("ch2_excl", 26'h000_00FF, 1'b1, 3'b000, 3'b010, 1'b0);

        // If channel 2 still voted, m would be 3FF_FFFF; excluded, m = a1 & a3.
        a1 = 26'h3FF_FFFF; a2 = 26'h3FF_FFFF; a3 = 26'h3FF_FF00;
        tick();
        check_all("ch2_excl2", 26'h000_00FF, 1'b1, 3'b001, 3'b010, 1'b0);
        check("ch2_excl2.cnt0", 32'(dut.cnt[0]), 32'd1);

        // Clear fault[1] on an idle cycle.
        valid     = 1'b0;
        fault_clr = 3'b010;
        tick();
        fault_clr = 3'b000;
        check_all("clr_idle", 26'h000_00FF, 1'b0, 3'b001, 3'b000, 1'b0);
        check("clr_idle.cnt1", 32'(dut.cnt[1]), 32'd0);

        // Channel 3: mis, mis, agree, mis, mis -> counter restarts, no fault.
        valid = 1'b1;
        a1 = 26'h0AB_CDEF; a2 = 26'h0AB_CDEF; a3 = 26'h0AB_CDEE;
        tick();
        check_all("ch3_m1", 26'h354_3210, 1'b1, 3'b100, 3'b000, 1'b0);
        check("ch3_m1.cnt0", 32'(dut.cnt[0]), 32'd0);
        check("ch3_m1.cnt2", 32'(dut.cnt[2]), 32'd1);
        tick();
        check("ch3_m2.cnt2", 32'(dut.cnt[2]), 32'd2);
        a3 = 26'h0AB_CDEF;
        tick();
        check_all("ch3_agree", 26'h354_3210, 1'b1, 3'b000, 3'b000, 1'b0);
        check("ch3_agree.cnt2", 32'(dut.cnt[2]), 32'd0);
        a3 = 26'h0AB_CDEE;
        tick();
        tick();
        check_all("ch3_m4", 26'h354_3210, 1'b1, 3'b100, 3'b000, 1'b0);
        check("ch3_m4.cnt2", 32'(dut.cnt[2]), 32'd2);
        a3 = 26'h0AB_CDEF;
        tick();
        check("ch3_done.cnt2", 32'(dut.cnt[2]), 32'd0);

        // Fault channel 1, clear it, then clear on the same cycle as a set.
        a1 = 26'h111_1111; a2 = 26'h222_2222; a3 = 26'h222_2222;
        tick();
        tick();
        tick();
        check_all("ch1_fault", 26'h1DD_DDDD, 1'b1, 3'b001, 3'b001, 1'b0);
        valid     = 1'b0;
        fault_clr = 3'b001;
        tick();
        fault_clr = 3'b000;
        check("ch1_clr.fault", 32'(fault), 32'd0);
        check("ch1_clr.cnt0", 32'(dut.cnt[0]), 32'd0);
        valid = 1'b1;
        tick();
        tick();
        check("ch1_re2.cnt0", 32'(dut.cnt[0]), 32'd2);
        fault_clr = 3'b001;
        tick();
        fault_clr = 3'b000;
        check_all("clr_wins", 26'h1DD_DDDD, 1'b1, 3'b001, 3'b000, 1'b0);
        check("clr_wins.cnt0", 32'(dut.cnt[0]), 32'd0);

        // Only channel 1 enabled: no quorum, m = 0, no faults, counter holds.
        en = 3'b001;
        a1 = 26'h123_4567; a2 = 26'h000_0000; a3 = 26'h000_0000;
        tick();
        check_all("noq1", 26'h3FF_FFFF, 1'b1, 3'b001, 3'b000, 1'b1);
        tick();
        tick();
        tick();
        check_all("noq4", 26'h3FF_FFFF, 1'b1, 3'b001, 3'b000, 1'b1);
        check("noq4.cnt0", 32'(dut.cnt[0]), 32'd0);

        // Reset mid-stream with valid still high.
        rst = 1'b1;
        tick();
        check_all("rst_mid", 26'h3FF_FFFF, 1'b0, 3'b000, 3'b000, 1'b0);

        // Normal voting resumes after reset.
        rst = 1'b0;
        en  = 3'b111;
        a1 = 26'h0F0_F0F0; a2 = 26'h0F0_F0F0; a3 = 26'h333_3333;
        tick();
        check_all("post_rst", 26'h30F_0F0F, 1'b1, 3'b100, 3'b000, 1'b0);

`ifdef TMR_ERR_INJECT_EN
        // Inject a single-bit error into channel 3 on equal inputs.
        a1 = 26'h0AB_CDEF; a2 = 26'h0AB_CDEF; a3 = 26'h0AB_CDEF;
        inj_sel  = 3'b100;
        inj_mask = 26'h000_0001;
        tick();
        check_all("inject", 26'h354_3210, 1'b1, 3'b100, 3'b000, 1'b0);
        check("inject.cnt2", 32'(dut.cnt[2]), 32'd2);
        inj_sel = 3'b000;
        tick();
        check_all("inject_off", 26'h354_3210, 1'b1, 3'b000, 3'b000, 1'b0);
`endif

        valid = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tmr_vote_reg.md
Name: tmr_vote_reg

Overview:
- Parametrised, registered triple-modular-redundancy word voter.
- Votes three WIDTH-bit channel words bit-wise (2-of-3), with per-channel enables, as the single-bit voter does.
- Adds per-channel miscompare detection, consecutive-miscompare counting, channel fault latching with automatic exclusion, and quorum loss detection.
- Sits at the output of triplicated register or ALU lanes in the LVDC datapath model.

Parameters:
- WIDTH, 26, channel word width in bits.
- FAULT_LIMIT, 3, number of consecutive miscompared samples that latches a channel fault; legal range 1..2^CNT_W-1.
- CNT_W, 4, width of each consecutive-miscompare counter.
- INVERT, 1. When 1, `y` is the complemented majority (matches the existing NAND-style voter). When 0, `y` is the true majority.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- valid  in  1  sample strobe; channel inputs are voted when high
- en  in  3  per-channel enable; bit k gates channel k+1
- a1  in  WIDTH  channel 1 word
- a2  in  WIDTH  channel 2 word
- a3  in  WIDTH  channel 3 word
- fault_clr  in  3  per-channel fault clear, one bit per channel
- y  out  WIDTH  registered vote (polarity per INVERT)
- y_valid  out  1  high one cycle after a voted sample
- miscmp  out  3  registered per-channel miscompare flag for the last sample
- fault  out  3  latched per-channel fault
- no_quorum  out  1  registered; high when fewer than 2 channels are effective

Behaviour:
- Effective enable: `eff[k] = en[k] & ~fault[k]`.
- Gated word: `g_k = eff[k] ? a_k : 0`.
- Majority: `m = (g1&g2)|(g1&g3)|(g2&g3)`, bit-wise.
- On a cycle with valid=1:
  - next cycle `y = INVERT ? ~m : m`, `y_valid = 1`.
  - `miscmp[k] = eff[k] & (a_k != m)` over the full word.
- On a cycle with valid=0:
  - `y` holds its value; `y_valid = 0`; `miscmp` holds.
- Latency: exactly one clock from `valid` to `y` / `y_valid` / `miscmp`.
- Per-channel counter `cnt[k]`, updated only on valid cycles:
  - `eff[k]` and miscompare: increment, saturating at FAULT_LIMIT.
  - `eff[k]` and agreement: cleared to 0.
  - `eff[k]=0`: holds.
- Fault set: `fault[k]` sets in the cycle `cnt[k]` would reach FAULT_LIMIT. It is registered together with that sample's `y`, so the faulted channel is excluded starting with the next sample.
- Fault clear: `fault_clr[k]=1` clears `fault[k]` and `cnt[k]` next cycle.
  - Clear has priority over a same-cycle set for that channel.
  - Clear applies whether or not `valid` is high.
- `no_quorum` is registered every cycle as `popcount(eff) < 2` (eff evaluated with current `en` and `fault`).
  - When it is high, voting continues: the gated-zero rule still applies (one effective channel gives `m = 0`; none gives `m = 0`).
  - No channel is faulted while `no_quorum` is high; counters hold.
- With all three channels effective, a single-channel error never corrupts `y`.
- Simultaneous miscompare on two channels in one sample: both counters increment. Both may fault on the same cycle.
- Reset (any cycle, including mid-stream):
  - `y = INVERT ? all-ones : 0`.
  - `y_valid = 0`, `miscmp = 0`, `fault = 0`, all `cnt = 0`.
  - `no_quorum = 0`.

Optional Feature:
- Macro: TMR_ERR_INJECT_EN.
- Defined: adds ports `inj_sel in 3` and `inj_mask in WIDTH`.
  - When `valid=1`, each channel k with `inj_sel[k]=1` has `a_k ^ inj_mask` substituted before gating, voting and miscompare.
  - Injection is a single-sample effect.
- Undefined: the ports are absent and the inputs are used unmodified.
- Behaviour with `inj_sel=0` is identical to undefined.

Test Plan:
- Reset then `en=3'b111`, `a1=a2=a3=26'h155_5555`, `valid=1`, INVERT=1: next cycle `y=26'h2AA_AAAA`, `y_valid=1`, `miscmp=0`, `fault=0`, `no_quorum=0`.
- `a2=26'h000_00FF`, others `26'h3FF_FF00`, 3 consecutive valid samples: `y=26'h000_00FF` (inverted majority) each sample, `miscmp=3'b010`. `fault[1]` rises with the 3rd sample's result. A 4th sample with `a2=26'h3FF_FFFF` gives `miscmp=0` and `y` from channels 1 and 3 only.
- Channel 3 miscompares 2 samples, agrees 1, miscompares 2: `cnt` resets on the agreeing sample, `fault` stays 0.
- With `fault[0]=1`, pulse `fault_clr=3'b001` in the same cycle as a 3rd miscompare: `fault[0]=0` and `cnt[0]=0` next cycle (clear wins).
- `en=3'b001`: `no_quorum=1` next cycle, `y=all-ones` (m=0), no faults set despite miscompare on channel 1. Assert `rst` mid-stream: all outputs return to reset values one cycle later.
- (TMR_ERR_INJECT_EN) `inj_sel=3'b100`, `inj_mask=26'h000_0001`, equal inputs: `y` unchanged, `miscmp=3'b100`, `cnt[2]=1`.
